// File: rtl/uvmt_cv32e40x_sl_obi_arbiter_if.sv
// OBI bundle for the two-requester arbiter: requester-side m_* and responder-side s_* signals.
// slave modport is the arbiter's view; master modport is the surrounding requesters/responder.
interface uvmt_cv32e40x_sl_obi_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [1:0]                    m_req_i;
    logic [1:0]                    m_gnt_o;
    logic [2*ADDR_WIDTH-1:0]       m_addr_i;
    logic [1:0]                    m_we_i;
    logic [2*(DATA_WIDTH/8)-1:0]   m_be_i;
    logic [2*DATA_WIDTH-1:0]       m_wdata_i;
    logic [1:0]                    m_rvalid_o;
    logic [DATA_WIDTH-1:0]         m_rdata_o;

    logic                          s_req_o;
    logic                          s_gnt_i;
    logic [ADDR_WIDTH-1:0]         s_addr_o;
    logic                          s_we_o;
    logic [DATA_WIDTH/8-1:0]       s_be_o;
    logic [DATA_WIDTH-1:0]         s_wdata_o;
    logic                          s_rvalid_i;
    logic [DATA_WIDTH-1:0]         s_rdata_i;

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        input  s_gnt_i, s_rvalid_i, s_rdata_i
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        output s_gnt_i, s_rvalid_i, s_rdata_i
    );
endinterface

// File: rtl/uvmt_cv32e40x_sl_obi_arbiter.sv
// Two-requester to one-responder OBI arbiter with address-phase hold and in-order response ID FIFO.
// Define UVMT_CV32E40X_OBI_ARB_FIXED_PRIO_EN for fixed priority (requester 1 wins); default is round-robin.
module uvmt_cv32e40x_sl_obi_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    uvmt_cv32e40x_sl_obi_arbiter_if.slave        obi,
    output logic [2:0]                           outstanding_o,
    output logic                                 protocol_err_o
);
    localparam logic [0:0]  IDLE  = 1'b0;
    localparam logic [0:0]  HOLD  = 1'b1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam logic [2:0]  DEPTH = 3'(MAX_OUTSTANDING);

    logic [0:0]                 state_q, state_d;
    logic                       hold_id_q, hold_id_d;
    logic [2:0]                 count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic                       err_q, err_d;

    logic       arb_id;
    logic       sel;
    logic       req_any;
    logic       pop;
    logic       space;
    logic       s_req;
    logic       push;
    logic       head_id;
    logic [1:0] gnt;
    logic [1:0] rvalid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef UVMT_CV32E40X_OBI_ARB_FIXED_PRIO_EN
    assign arb_id = obi.m_req_i[1];
`else
    logic rr_q;

    // With a single requester that id wins; on contention the pointer id wins.
    assign arb_id = (&obi.m_req_i) ? rr_q : obi.m_req_i[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else if (push) begin
            rr_q <= ~sel;
        end
    end
`endif

    always_comb begin
        sel     = (state_q == HOLD) ? hold_id_q : arb_id;
        req_any = (state_q == HOLD) || (|obi.m_req_i);
        pop     = obi.s_rvalid_i && (count_q != '0);
        // A response in the same cycle frees a slot, so a full FIFO can still accept.
        space   = (count_q != DEPTH) || pop;
        s_req   = !rst_i && req_any && space;
        push    = s_req && obi.s_gnt_i;
        head_id = fifo_q[rd_ptr_q];

        gnt         = '0;
        gnt[sel]    = push;
        rvalid      = '0;
        rvalid[head_id] = pop;
    end

    assign obi.s_req_o    = s_req;
    assign obi.m_gnt_o    = gnt;
    assign obi.m_rvalid_o = rvalid;
    assign obi.m_rdata_o  = obi.s_rdata_i;
    assign obi.s_addr_o   = sel ? obi.m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : obi.m_addr_i[ADDR_WIDTH-1:0];
    assign obi.s_we_o     = obi.m_we_i[sel];
    assign obi.s_be_o     = sel ? obi.m_be_i[2*BE_W-1:BE_W] : obi.m_be_i[BE_W-1:0];
    assign obi.s_wdata_o  = sel ? obi.m_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : obi.m_wdata_i[DATA_WIDTH-1:0];

    assign outstanding_o  = count_q;
    assign protocol_err_o = err_q;

    always_comb begin
        count_d   = count_q + 3'(push) - 3'(pop);
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        err_d     = err_q || (obi.s_rvalid_i && (count_q == '0));
        state_d   = state_q;
        hold_id_d = hold_id_q;
        case (state_q)
            IDLE: begin
                if (s_req && !obi.s_gnt_i) begin
                    state_d   = HOLD;
                    hold_id_d = sel;
                end
            end
            default: begin
                if (push) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            hold_id_q <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fifo_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
            end
        end
    end
endmodule

// File: tb/tb_uvmt_cv32e40x_sl_obi_arbiter.sv
// Directed bench for the OBI arbiter: arbitration order, hold, FIFO-full blocking, routing, errors, reset.
module tb_uvmt_cv32e40x_sl_obi_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [2:0] outstanding_o;
    logic       protocol_err_o;

    int nvec = 0;
    int nerr = 0;

    uvmt_cv32e40x_sl_obi_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) obi ();

    uvmt_cv32e40x_sl_obi_arbiter #(
        .MAX_OUTSTANDING(2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .obi            (obi.slave),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then let combinational outputs settle.
    task automatic step(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        @(posedge clk_i);
        #1;
        obi.m_req_i    = req;
        obi.s_gnt_i    = gnt;
        obi.s_rvalid_i = rv;
        obi.s_rdata_i  = rd;
        #1;
    endtask

    initial begin
        obi.m_addr_i   = {32'h0000_1000, 32'h0000_0100};
        obi.m_we_i     = 2'b10;
        obi.m_be_i     = {4'hF, 4'h3};
        obi.m_wdata_i  = {32'hBBBB_0001, 32'hAAAA_0000};
        obi.m_req_i    = '0;
        obi.s_gnt_i    = 1'b0;
        obi.s_rvalid_i = 1'b0;
        obi.s_rdata_i  = '0;

        // Reset holds every output low even with requests and a response present.
        step(2'b11, 1'b1, 1'b1, 32'h1);
        chk("rst_s_req", 64'(obi.s_req_o), 64'd0);
        chk("rst_m_gnt", 64'(obi.m_gnt_o), 64'd0);
        chk("rst_m_rvalid", 64'(obi.m_rvalid_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_err", 64'(protocol_err_o), 64'd0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;

        // Single requester 0 read.
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t1_s_req", 64'(obi.s_req_o), 64'd1);
        chk("t1_gnt", 64'(obi.m_gnt_o), 64'h1);
        chk("t1_addr", 64'(obi.s_addr_o), 64'h100);
        chk("t1_be", 64'(obi.s_be_o), 64'h3);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t1_out1", 64'(outstanding_o), 64'd1);
        chk("t1_norv", 64'(obi.m_rvalid_o), 64'h0);
        step(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("t1_rvalid", 64'(obi.m_rvalid_o), 64'h1);
        chk("t1_rdata", 64'(obi.m_rdata_o), 64'hDEAD_BEEF);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t1_out0", 64'(outstanding_o), 64'd0);

        // Fresh reset so the pointer starts at requester 0.
        rst_i = 1'b1;
        step(2'b00, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;

        // Both requesters every cycle, responder grants and answers one cycle later.
        for (int k = 0; k < 5; k++) begin
            step((k < 4) ? 2'b11 : 2'b00, k < 4, k > 0, 32'h5000 + 32'(k));
            chk("t2_gnt", 64'(obi.m_gnt_o), (k >= 4) ? 64'h0 : ((k % 2 == 0) ? 64'h1 : 64'h2));
            chk("t2_rvalid", 64'(obi.m_rvalid_o), (k == 0) ? 64'h0 : (((k - 1) % 2 == 0) ? 64'h1 : 64'h2));
            chk("t2_out", 64'(outstanding_o), (k == 0) ? 64'd0 : 64'd1);
            if (k < 4) begin
                chk("t2_addr", 64'(obi.s_addr_o), (k % 2 == 0) ? 64'h100 : 64'h1000);
                chk("t2_we", 64'(obi.s_we_o), (k % 2 == 0) ? 64'd0 : 64'd1);
                chk("t2_wdata", 64'(obi.s_wdata_o), (k % 2 == 0) ? 64'hAAAA_0000 : 64'hBBBB_0001);
            end
        end
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t2_out0", 64'(outstanding_o), 64'd0);

        // Requester 1 held without grant while requester 0 (pointer id) also requests.
        step(2'b10, 1'b0, 1'b0, 32'h0);
        chk("t3_h0_addr", 64'(obi.s_addr_o), 64'h1000);
        chk("t3_h0_gnt", 64'(obi.m_gnt_o), 64'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("t3_h1_addr", 64'(obi.s_addr_o), 64'h1000);
        chk("t3_h1_req", 64'(obi.s_req_o), 64'd1);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("t3_h2_addr", 64'(obi.s_addr_o), 64'h1000);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t3_h3_gnt", 64'(obi.m_gnt_o), 64'h2);
        chk("t3_h3_addr", 64'(obi.s_addr_o), 64'h1000);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t3_h4_gnt", 64'(obi.m_gnt_o), 64'h1);
        chk("t3_h4_addr", 64'(obi.s_addr_o), 64'h100);
        step(2'b00, 1'b0, 1'b1, 32'h11);
        chk("t3_out2", 64'(outstanding_o), 64'd2);
        chk("t3_rv_first", 64'(obi.m_rvalid_o), 64'h2);
        step(2'b00, 1'b0, 1'b1, 32'h22);
        chk("t3_rv_second", 64'(obi.m_rvalid_o), 64'h1);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t3_out0", 64'(outstanding_o), 64'd0);

        // FIFO full: third request blocked until a response frees a slot in the same cycle.
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t4_g0", 64'(obi.m_gnt_o), 64'h1);
        step(2'b10, 1'b1, 1'b0, 32'h0);
        chk("t4_g1", 64'(obi.m_gnt_o), 64'h2);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t4_full_req", 64'(obi.s_req_o), 64'd0);
        chk("t4_full_gnt", 64'(obi.m_gnt_o), 64'h0);
        chk("t4_full_out", 64'(outstanding_o), 64'd2);
        step(2'b01, 1'b1, 1'b1, 32'h33);
        chk("t4_pop_req", 64'(obi.s_req_o), 64'd1);
        chk("t4_pop_gnt", 64'(obi.m_gnt_o), 64'h1);
        chk("t4_pop_rv", 64'(obi.m_rvalid_o), 64'h1);
        step(2'b00, 1'b0, 1'b1, 32'h44);
        chk("t4_out_stay2", 64'(outstanding_o), 64'd2);
        chk("t4_rv_id1", 64'(obi.m_rvalid_o), 64'h2);
        step(2'b00, 1'b0, 1'b1, 32'h55);
        chk("t4_rv_id0", 64'(obi.m_rvalid_o), 64'h1);
        chk("t4_out1", 64'(outstanding_o), 64'd1);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t4_out0", 64'(outstanding_o), 64'd0);
        chk("t4_noerr", 64'(protocol_err_o), 64'd0);

        // Response with nothing outstanding.
        step(2'b00, 1'b0, 1'b1, 32'h66);
        chk("t5_norv", 64'(obi.m_rvalid_o), 64'h0);
        chk("t5_err_pre", 64'(protocol_err_o), 64'd0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t5_err_set", 64'(protocol_err_o), 64'd1);
        chk("t5_out0", 64'(outstanding_o), 64'd0);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t5_err_sticky", 64'(protocol_err_o), 64'd1);

        // Reset mid-transaction while holding requester 1 with one outstanding.
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t6_g0", 64'(obi.m_gnt_o), 64'h1);
        step(2'b10, 1'b0, 1'b0, 32'h0);
        chk("t6_hold_gnt", 64'(obi.m_gnt_o), 64'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("t6_hold_addr", 64'(obi.s_addr_o), 64'h1000);
        chk("t6_out1", 64'(outstanding_o), 64'd1);
        obi.s_gnt_i    = 1'b1;
        obi.s_rvalid_i = 1'b1;
        rst_i          = 1'b1;
        #1;
        chk("t6_rst_req", 64'(obi.s_req_o), 64'd0);
        chk("t6_rst_gnt", 64'(obi.m_gnt_o), 64'h0);
        chk("t6_rst_rv", 64'(obi.m_rvalid_o), 64'h0);
        chk("t6_rst_out", 64'(outstanding_o), 64'd0);
        chk("t6_rst_err", 64'(protocol_err_o), 64'd0);
        step(2'b00, 1'b0, 1'b1, 32'h77);
        rst_i = 1'b0;
        #1;
        chk("t6_late_rv", 64'(obi.m_rvalid_o), 64'h0);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t6_first_gnt", 64'(obi.m_gnt_o), 64'h1);
        chk("t6_first_addr", 64'(obi.s_addr_o), 64'h100);
        chk("t6_late_err", 64'(protocol_err_o), 64'd1);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t6_out1_after", 64'(outstanding_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
